// File: rtl/memc_pkg.sv
// Shared MEMC datapath constants, block descriptor payload and coordinate-stage encodings.
package memc_pkg;

    localparam int unsigned FRAME_W      = 64;
    localparam int unsigned FRAME_H      = 48;
    localparam int unsigned FRAME_W_LOG2 = 6;
    localparam int unsigned WIN_SIZE     = 12;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned ADDR_W       = 12;

    localparam int unsigned COORD_W = 6;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WIN_W   = 4;

    // Coordinate-stage states that block fetch is sequenced against
    localparam logic [2:0] CS_IDLE  = 3'd0;
    localparam logic [2:0] CS_CLAMP = 3'd1;
    localparam logic [2:0] CS_ISSUE = 3'd2;
    localparam logic [2:0] CS_WAIT  = 3'd3;
    localparam logic [2:0] CS_NEXT  = 3'd4;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        logic [CNT_W-1:0]   row_max;
        logic [CNT_W-1:0]   col_max;
        logic [WIN_W-1:0]   pad_row;
        logic [WIN_W-1:0]   pad_col;
    } blk_desc_t;

    // Window coordinate wraps modulo the 4-bit window index space
    function automatic logic [WIN_W-1:0] win_add(input logic [WIN_W-1:0] pad,
                                                 input logic [CNT_W-1:0] ofs);
        return WIN_W'(pad + WIN_W'(ofs));
    endfunction

endpackage

// File: rtl/block_fetch_ctr.sv
// 2-D raster counter: walks (r, c) row-major over max_r x max_c, flags the final position.
module block_fetch_ctr
    import memc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] max_r,
    input  logic [CNT_W-1:0] max_c,
    input  logic             load,
    input  logic             step,
    output logic [CNT_W-1:0] r,
    output logic [CNT_W-1:0] c,
    output logic             last
);

    logic [CNT_W-1:0] r_d;
    logic [CNT_W-1:0] c_d;

    always_comb begin
        r_d = r;
        c_d = c;
        if (load) begin
            r_d = '0;
            c_d = '0;
        end else if (step) begin
            if (c == CNT_W'(max_c - 1'b1)) begin
                c_d = '0;
                r_d = CNT_W'(r + 1'b1);
            end else begin
                c_d = CNT_W'(c + 1'b1);
            end
        end
    end

    // last is precomputed from the next position so it is a flop, not a compare
    always_ff @(posedge clk) begin
        if (rst) begin
            r    <= '0;
            c    <= '0;
            last <= 1'b0;
        end else begin
            r <= r_d;
            c <= c_d;
            if (load || step) begin
                last <= (r_d == CNT_W'(max_r - 1'b1)) && (c_d == CNT_W'(max_c - 1'b1));
            end
        end
    end

endmodule

// File: rtl/block_fetch.sv
// Raster block fetch: reads a clamped block from frame SRAM and writes it into the
// search-window buffer at its padded coordinate, then pulses done.
module block_fetch #(
    parameter int unsigned PIX_W        = memc_pkg::PIX_W,
    parameter int unsigned FRAME_W_LOG2 = memc_pkg::FRAME_W_LOG2,
    parameter int unsigned ADDR_W       = memc_pkg::ADDR_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ADDR_W-FRAME_W_LOG2-1:0]      blk_row,
    input  logic [FRAME_W_LOG2-1:0]             blk_col,
    input  logic [memc_pkg::CNT_W-1:0]          row_cnt_max,
    input  logic [memc_pkg::CNT_W-1:0]          col_cnt_max,
    input  logic [memc_pkg::WIN_W-1:0]          pad_row,
    input  logic [memc_pkg::WIN_W-1:0]          pad_col,
    output logic                                busy,
    output logic                                done,
    output logic                                sram_rd,
    output logic [ADDR_W-1:0]                   sram_addr,
    input  logic [PIX_W-1:0]                    sram_q,
    output logic                                win_we,
    output logic [memc_pkg::WIN_W-1:0]          win_row,
    output logic [memc_pkg::WIN_W-1:0]          win_col,
    output logic [PIX_W-1:0]                    win_data
);

    import memc_pkg::*;

    localparam int unsigned ROW_W = ADDR_W - FRAME_W_LOG2;
    localparam int unsigned COL_W = FRAME_W_LOG2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    blk_desc_t        blk_q;
    blk_desc_t        blk_d;
    logic [ROW_W-1:0] addr_row_q;
    logic [ROW_W-1:0] addr_row_d;
    logic [COL_W-1:0] addr_col_q;
    logic [COL_W-1:0] addr_col_d;
    logic             busy_d;
    logic             done_d;
    logic             sram_rd_d;
    logic             win_we_d;
    logic [WIN_W-1:0] win_row_d;
    logic [WIN_W-1:0] win_col_d;

    logic             ctr_load;
    logic             ctr_step;
    logic [CNT_W-1:0] ctr_max_r;
    logic [CNT_W-1:0] ctr_max_c;
    logic [CNT_W-1:0] ctr_r;
    logic [CNT_W-1:0] ctr_c;
    logic             ctr_last;

    block_fetch_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .max_r (ctr_max_r),
        .max_c (ctr_max_c),
        .load  (ctr_load),
        .step  (ctr_step),
        .r     (ctr_r),
        .c     (ctr_c),
        .last  (ctr_last)
    );

    // Next-state and registered-output values
    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        addr_row_d = addr_row_q;
        addr_col_d = addr_col_q;
        busy_d     = busy;
        done_d     = 1'b0;
        sram_rd_d  = 1'b0;
        win_we_d   = 1'b0;
        win_row_d  = win_row;
        win_col_d  = win_col;
        ctr_load   = 1'b0;
        ctr_step   = 1'b0;
        ctr_max_r  = blk_q.row_max;
        ctr_max_c  = blk_q.col_max;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    blk_d.row     = COORD_W'(blk_row);
                    blk_d.col     = COORD_W'(blk_col);
                    blk_d.row_max = row_cnt_max;
                    blk_d.col_max = col_cnt_max;
                    blk_d.pad_row = pad_row;
                    blk_d.pad_col = pad_col;
                    busy_d        = 1'b1;
                    // counter loads in the same edge, so it sees the live sizes
                    ctr_max_r     = row_cnt_max;
                    ctr_max_c     = col_cnt_max;
                    if (row_cnt_max == '0 || col_cnt_max == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_READ;
                        sram_rd_d  = 1'b1;
                        addr_row_d = blk_row;
                        addr_col_d = blk_col;
                        ctr_load   = 1'b1;
                    end
                end
            end

            ST_READ: begin
                win_we_d  = 1'b1;
                win_row_d = win_add(blk_q.pad_row, ctr_r);
                win_col_d = win_add(blk_q.pad_col, ctr_c);
                if (ctr_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    sram_rd_d = 1'b1;
                    ctr_step  = 1'b1;
                    if (ctr_c == CNT_W'(blk_q.col_max - 1'b1)) begin
                        addr_col_d = COL_W'(blk_q.col);
                        addr_row_d = ROW_W'(addr_row_q + 1'b1);
                    end else begin
                        addr_col_d = COL_W'(addr_col_q + 1'b1);
                    end
                end
            end

            ST_DRAIN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            blk_q      <= '0;
            addr_row_q <= '0;
            addr_col_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sram_rd    <= 1'b0;
            win_we     <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            addr_row_q <= addr_row_d;
            addr_col_q <= addr_col_d;
            busy       <= busy_d;
            done       <= done_d;
            sram_rd    <= sram_rd_d;
            win_we     <= win_we_d;
            win_row    <= win_row_d;
            win_col    <= win_col_d;
        end
    end

    assign sram_addr = {addr_row_q, addr_col_q};
    assign win_data  = sram_q;

endmodule

// File: tb/tb_block_fetch.sv
// Scoreboard bench for block_fetch: stimulus pushes expected reads/writes/done, a monitor pops and compares.
module tb_block_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  blk_row;
    logic [5:0]  blk_col;
    logic [3:0]  row_cnt_max;
    logic [3:0]  col_cnt_max;
    logic [3:0]  pad_row;
    logic [3:0]  pad_col;
    logic        busy;
    logic        done;
    logic        sram_rd;
    logic [11:0] sram_addr;
    logic [7:0]  sram_q;
    logic        win_we;
    logic [3:0]  win_row;
    logic [3:0]  win_col;
    logic [7:0]  win_data;

    block_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .blk_row     (blk_row),
        .blk_col     (blk_col),
        .row_cnt_max (row_cnt_max),
        .col_cnt_max (col_cnt_max),
        .pad_row     (pad_row),
        .pad_col     (pad_col),
        .busy        (busy),
        .done        (done),
        .sram_rd     (sram_rd),
        .sram_addr   (sram_addr),
        .sram_q      (sram_q),
        .win_we      (win_we),
        .win_row     (win_row),
        .win_col     (win_col),
        .win_data    (win_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int a;
        int b;
        int d;
    } ev_t;

    ev_t  rd_q[$];
    ev_t  wr_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   mon_en = 1'b0;
    logic [7:0] mem [4096];

    always @(posedge clk) cyc <= cyc + 1;

    // Frame SRAM model: one-cycle read latency, garbage when idle
    always @(posedge clk) begin
        if (sram_rd) sram_q <= mem[sram_addr];
        else         sram_q <= 8'($urandom);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (sram_rd) begin
                if (rd_q.size() == 0) check("rd_unexpected_cycle", cyc, -1);
                else begin
                    e = rd_q.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_addr", int'(sram_addr), e.a);
                end
            end
            if (win_we) begin
                if (wr_q.size() == 0) check("wr_unexpected_cycle", cyc, -1);
                else begin
                    e = wr_q.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_row", int'(win_row), e.a);
                    check("wr_col", int'(win_col), e.b);
                    check("wr_data", int'(win_data), e.d);
                end
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected_cycle", cyc, -1);
                else check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one start; model the whole block in raster order. cut>=0 means rst lands in cycle t0+cut.
    task automatic issue(input int br, input int bc, input int rm, input int cm,
                         input int pr, input int pc, input int cut,
                         output int t0, output int dn);
        int n;
        int k;
        int addr;
        ev_t e;
        t0 = cyc;
        n  = rm * cm;
        dn = (n == 0) ? t0 + 1 : t0 + n + 2;
        blk_row = 6'(br);
        blk_col = 6'(bc);
        row_cnt_max = 4'(rm);
        col_cnt_max = 4'(cm);
        pad_row = 4'(pr);
        pad_col = 4'(pc);
        start = 1'b1;
        k = 0;
        for (int r = 0; r < rm; r++) begin
            for (int c = 0; c < cm; c++) begin
                addr = ((br + r) % 64) * 64 + ((bc + c) % 64);
                if (cut < 0 || 1 + k <= cut) begin
                    e.cyc = t0 + 1 + k; e.a = addr; e.b = 0; e.d = 0;
                    rd_q.push_back(e);
                end
                if (cut < 0 || 2 + k <= cut) begin
                    e.cyc = t0 + 2 + k; e.a = (pr + r) % 16; e.b = (pc + c) % 16;
                    e.d = int'(mem[addr]);
                    wr_q.push_back(e);
                end
                k++;
            end
        end
        busy_lo = t0 + 1;
        if (cut < 0) begin
            done_q.push_back(dn);
            busy_hi = dn;
        end else begin
            busy_hi = t0 + cut;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        blk_row = 6'($urandom);
        blk_col = 6'($urandom);
        row_cnt_max = 4'($urandom);
        col_cnt_max = 4'($urandom);
        pad_row = 4'($urandom);
        pad_col = 4'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_sram_rd"}, int'(sram_rd), 0);
        check({tag, "_sram_addr"}, int'(sram_addr), 0);
        check({tag, "_win_we"}, int'(win_we), 0);
        check({tag, "_win_row"}, int'(win_row), 0);
        check({tag, "_win_col"}, int'(win_col), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int dn;
        int rm;
        int cm;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        rst = 1'b1;
        start = 1'b0;
        blk_row = '0; blk_col = '0; row_cnt_max = '0; col_cnt_max = '0;
        pad_row = '0; pad_col = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Aligned 8x8 block
        issue(8, 16, 8, 8, 0, 0, -1, t0, dn);
        check("aligned_first_addr", int'(sram_addr), 528);
        go_to(dn + 1);

        // Top-left clamped block with padding
        issue(0, 0, 10, 10, 2, 2, -1, t0, dn);
        go_to(dn + 1);

        // Degenerate blocks, back to back at the earliest accept cycle
        issue(5, 7, 6, 0, 1, 1, -1, t0, dn);
        go_to(dn + 1);
        issue(40, 60, 0, 4, 3, 0, -1, t0, dn);
        go_to(dn + 1);

        // Starts while busy and during DONE are ignored
        issue(20, 30, 12, 2, 0, 5, -1, t0, dn);
        go_to(t0 + 5);
        blk_row = 6'd1; blk_col = 6'd1; row_cnt_max = 4'd3; col_cnt_max = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        go_to(dn);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        go_to(dn + 3);

        // Reset mid-fetch, then a clean fetch from (0,0)
        issue(8, 16, 8, 8, 0, 0, 10, t0, dn);
        go_to(t0 + 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        issue(3, 9, 4, 5, 7, 6, -1, t0, dn);
        go_to(dn + 1);

        // Randomized in-bounds blocks with random idle gaps
        for (int it = 0; it < 24; it++) begin
            rm = $urandom_range(0, 12);
            cm = $urandom_range(0, 12);
            issue($urandom_range(0, 48 - rm), $urandom_range(0, 64 - cm), rm, cm,
                  $urandom_range(0, 12 - rm), $urandom_range(0, 12 - cm), -1, t0, dn);
            go_to(dn + 1 + $urandom_range(0, 3));
        end

        repeat (4) @(posedge clk);
        #1;
        check("rd_left", rd_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        check("done_left", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_fetch.md
# block_fetch

Raster fetch engine directly downstream of the coordinate stage in the MEMC datapath. On a start pulse it latches a frame-clamped block (address, size, pad offset) and reads it pixel by pixel from the frame SRAM. It writes each returned pixel into the 12x12 search-window buffer at the padded window coordinate. It signals completion with a one-cycle done pulse so the main FSM can advance.

## Interface
- PIX_W, 8, pixel width
- FRAME_W_LOG2, 6, log2 of frame width (64 columns)
- ADDR_W, 12, frame SRAM address width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches all block parameters
- blk_row  in  6  block origin row in frame
- blk_col  in  6  block origin column in frame
- row_cnt_max  in  4  block height in pixels (0..12)
- col_cnt_max  in  4  block width in pixels (0..12)
- pad_row  in  4  window row offset of the block's first row
- pad_col  in  4  window column offset of the block's first column
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- sram_rd  out  1  frame SRAM read strobe
- sram_addr  out  ADDR_W  frame SRAM address
- sram_q  in  PIX_W  read data, valid exactly one cycle after sram_rd
- win_we  out  1  window buffer write enable
- win_row  out  4  window write row
- win_col  out  4  window write column
- win_data  out  PIX_W  window write data (equals sram_q)

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE
  - start=1 latches blk_row/col, row/col_cnt_max and pad_row/col.
  - Either max == 0: go to DONE; no reads are issued.
  - Otherwise: go to READ with r=0, c=0.
- READ
  - Every cycle: sram_rd=1 and sram_addr={blk_row+r, blk_col+c}, each sum taken 6-bit modulo.
  - c increments each cycle. When c == col_cnt_max-1, c resets to 0 and r increments.
  - After the read for (row_cnt_max-1, col_cnt_max-1) is issued, go to DRAIN.
- Write pipeline
  - One register stage carries (r, c, valid) alongside each read.
  - On the cycle after each read: win_we=1, win_row=pad_row+r, win_col=pad_col+c (4-bit modulo), win_data=sram_q.
- DRAIN: no read; the final write occurs here; go to DONE.
- DONE: done=1 for one cycle; return to IDLE.
- start is ignored whenever the state is not IDLE, including the DONE cycle.
- No bounds checking. Upstream guarantees pad+max ≤ 12 and that the clamped block lies inside the 64x48 frame.
- Window cells outside the fetched region are left untouched. Pad fill is the window owner's responsibility.

## Timing
- Reset values: busy=0, done=0, sram_rd=0, sram_addr=0, win_we=0, win_row=0, win_col=0, win_data follows sram_q (don't-care while win_we=0).
- Let N = row_cnt_max*col_cnt_max, and let start be sampled at cycle 0.
  - Reads occur in cycles 1..N.
  - Writes occur in cycles 2..N+1.
  - done is high in cycle N+2.
- N=0: done is high in cycle 1; no sram_rd and no win_we.
- The next start is accepted at the earliest in cycle N+3.
- All outputs are registered except win_data.
- rst mid-operation
  - Returns to IDLE on the next edge.
  - The in-flight pipelined write is dropped: win_we=0 the cycle after rst is sampled.
  - done is not emitted.

## Structure
- Shared package memc_pkg holds:
  - FRAME_W=64, FRAME_H=48, WIN_SIZE=12, PIX_W=8, ADDR_W=12;
  - the coordinate-stage state encodings this block is sequenced against.
- The block's own state encoding stays local.
- One natural sub-module is block_fetch_ctr: a 2-D raster counter with inputs max_r/max_c, load and step, and outputs r, c and last.

## Test plan
- Aligned block: start with blk=(8,16), max=8x8, pad=(0,0).
  - Expect 64 reads; first sram_addr=528, last sram_addr=983.
  - First write to win(0,0), last to win(7,7); done at cycle 66.
- Top-left clamped block: blk=(0,0), max=10x10, pad=(2,2).
  - Expect 100 writes, first at win(2,2) and last at win(11,11), with win_data matching the SRAM model.
  - done at cycle 102.
- Degenerate block: max_col=0.
  - Expect no sram_rd and no win_we; done at cycle 1; busy high for exactly 1 cycle.
- Start while busy: second start at cycle 5 of a 12x2 fetch, and another start during the DONE cycle.
  - Both ignored; exactly 24 writes; single done at cycle 26.
- Reset mid-fetch: assert rst at cycle 10 of the 8x8 fetch.
  - From cycle 11 all outputs are at reset values; no done pulse.
  - A new start afterwards fetches correctly from r=0, c=0.
